// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two read ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and clears onto the read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_register_1,
    input  logic [ADDR_W-1:0] read_register_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              read_busy_1,
    output logic              read_busy_2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_count_q;
    logic [ADDR_W:0]   busy_count_d;
    logic              wr_en_s;
    logic              iss_en_s;
    logic              inc_s;
    logic              dec_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == {ADDR_W{1'b0}});
    endfunction

    function automatic logic [DATA_W-1:0] read_data_f(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              fwd
    );
        logic [DATA_W-1:0] res;
        if (is_zero_reg(idx)) begin
            res = {DATA_W{1'b0}};
        end else if (fwd) begin
            res = write_data;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    function automatic logic forward_hit(input logic [ADDR_W-1:0] idx);
`ifdef REGFILE_BYPASS_EN
        return rst_n && reg_write && (write_register == idx) && !is_zero_reg(idx);
`else
        return (idx != idx);
`endif
    endfunction

    // Next-state for storage, busy bits and the busy counter.
    always_comb begin
        wr_en_s  = reg_write && !is_zero_reg(write_register);
        iss_en_s = issue_valid && !is_zero_reg(issue_rd);
        regs_d   = regs_q;
        busy_d   = busy_q;
        if (wr_en_s) begin
            regs_d[write_register] = write_data;
            busy_d[write_register] = 1'b0;
        end else begin
            busy_d[write_register] = busy_q[write_register];
        end
        // Issue is applied after the clear so the newer writer wins on a collision.
        if (iss_en_s) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d[issue_rd] = busy_d[issue_rd];
        end
        inc_s = iss_en_s && !busy_q[issue_rd];
        dec_s = wr_en_s && busy_q[write_register] &&
                !(iss_en_s && (issue_rd == write_register));
        case ({inc_s, dec_s})
            2'b10:   busy_count_d = busy_count_q + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   busy_count_d = busy_count_q - {{ADDR_W{1'b0}}, 1'b1};
            default: busy_count_d = busy_count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            busy_q       <= {DEPTH{1'b0}};
            busy_count_q <= {(ADDR_W+1){1'b0}};
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        read_data_1 = read_data_f(read_register_1, regs_q[read_register_1],
                                  forward_hit(read_register_1));
        read_data_2 = read_data_f(read_register_2, regs_q[read_register_2],
                                  forward_hit(read_register_2));
        read_busy_1 = busy_q[read_register_1] && !forward_hit(read_register_1);
        read_busy_2 = busy_q[read_register_2] && !forward_hit(read_register_2);
        busy_count  = busy_count_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a stimulus process queues expected read-port
// values from an array-based reference model; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_register_1;
    logic [4:0]  read_register_2;
    logic [63:0] read_data_1;
    logic [63:0] read_data_2;
    logic        read_busy_1;
    logic        read_busy_2;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [63:0] write_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [5:0]  busy_count;

    regfile_scoreboard #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .read_busy_1(read_busy_1), .read_busy_2(read_busy_2),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_mem[32];
    bit          m_busy[32];
    bit          model_ok = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit bypassed(input logic rst, input logic we, input logic [4:0] wr,
                                    input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        return rst && we && (wr == idx) && (idx != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model_data(input logic rst, input logic we,
                                               input logic [4:0] wr, input logic [63:0] wd,
                                               input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (bypassed(rst, we, wr, idx)) return wd;
        return m_mem[idx];
    endfunction

    function automatic logic model_busy(input logic rst, input logic we,
                                        input logic [4:0] wr, input logic [4:0] idx);
        if (bypassed(rst, we, wr, idx)) return 1'b0;
        return m_busy[idx];
    endfunction

    task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        rst_n = rst; reg_write = we; write_register = wr; write_data = wd;
        issue_valid = iv; issue_rd = ird; read_register_1 = r1; read_register_2 = r2;
        if (model_ok) begin
            e.r1 = r1; e.r2 = r2;
            e.d1 = model_data(rst, we, wr, wd, r1);
            e.d2 = model_data(rst, we, wr, wd, r2);
            e.b1 = model_busy(rst, we, wr, r1);
            e.b2 = model_busy(rst, we, wr, r2);
            e.cnt = 6'(model_count());
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 64'd0;
                m_busy[i] = 1'b0;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (we && wr != 5'd0) m_mem[wr] = wd;
            if (we) m_busy[wr] = 1'b0;
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] idx, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s idx=%0d got=%h expected=%h", name, idx, got, want);
        end
    endtask

    // Monitor: read ports are combinational, so every driven cycle presents an output.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("read_data_1", e.r1, read_data_1, e.d1);
            chk("read_data_2", e.r2, read_data_2, e.d2);
            chk("read_busy_1", e.r1, {63'd0, read_busy_1}, {63'd0, e.b1});
            chk("read_busy_2", e.r2, {63'd0, read_busy_2}, {63'd0, e.b2});
            chk("busy_count", 5'd0, {58'd0, busy_count}, {58'd0, e.cnt});
        end
    end

    initial begin
        logic [4:0] wr;
        logic [4:0] ird;
        rst_n = 1'b0; reg_write = 1'b0; write_register = 5'd0; write_data = 64'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; read_register_1 = 5'd0; read_register_2 = 5'd0;
        #1;
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
        // Write during reset must be lost.
        step(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 5'd0, 5'd1);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        step(1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_0000_0001, 1'b0, 5'd0, 5'd31, 5'd31);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd31);
        step(1'b1, 1'b1, 5'd0, 64'hAB, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        step(1'b1, 1'b1, 5'd7, 64'h55, 1'b0, 5'd0, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd9);
        step(1'b1, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9, 5'd9);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        step(1'b1, 1'b1, 5'd9, 64'h9A, 1'b0, 5'd0, 5'd9, 5'd9);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd3, 64'h77, 1'b0, 5'd0, 5'd3, 5'd3);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 5'd1, 5'd2);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 5'd1, 5'd2);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd4, 5'd2);
        step(1'b0, 1'b1, 5'd6, 64'h66, 1'b1, 5'd8, 5'd1, 5'd4);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd1, 5'd4);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd2, 5'd6);
        // Randomised traffic, concentrated on a few indexes to force collisions.
        for (int n = 0; n < 3000; n++) begin
            wr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ird = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            step(($urandom_range(0, 199) != 0), 1'($urandom), wr, {$urandom, $urandom},
                 1'($urandom), ird, 5'($urandom_range(0, 9)), 5'($urandom));
        end
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
